// File: rtl/sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_motion_ctrl
//
// Frame-synchronous motion controller for the walking sprite. Watches the
// vertical sync of the VGA timing generator and, once per frame, advances the
// sprite origin, bounces it off the play-field limits, and steps the walk
// animation phase. Every output is registered and changes only in the cycle
// after the frame_start pulse, so the renderer never sees a torn update.
//
// Ports
//   clk          pixel clock, the only clock
//   reset        asynchronous, active-low reset
//   vsync        vertical sync from the timing generator (active = VSYNC_ACT)
//   enable       motion enable, sampled in the frame_start cycle
//   step_x       pixels per frame on x, sampled in the frame_start cycle
//   step_y       pixels per frame on y, sampled in the frame_start cycle
//   sprite_x     registered sprite origin x
//   sprite_y     registered sprite origin y
//   dir_x        1 = moving right, 0 = moving left
//   dir_y        1 = moving down,  0 = moving up
//   walk_phase   animation frame select for the sprite ROM
//   frame_start  one-cycle pulse at the leading edge of vsync
//   bounce       one-cycle pulse when either axis reverses
// -----------------------------------------------------------------------------
module sprite_motion_ctrl #(
  parameter int X_MIN       = 100,
  parameter int X_MAX       = 400,
  parameter int Y_MIN       = 40,
  parameter int Y_MAX       = 440,
  parameter int X_INIT      = 100,
  parameter int Y_INIT      = 100,
  parameter int STEP_W      = 3,
  parameter int ANIM_DIV    = 8,
  parameter int HOLD_FRAMES = 2,
  parameter bit VSYNC_ACT   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              enable,
  input  logic [STEP_W-1:0] step_x,
  input  logic [STEP_W-1:0] step_y,
  output logic [9:0]        sprite_x,
  output logic [9:0]        sprite_y,
  output logic              dir_x,
  output logic              dir_y,
  output logic [1:0]        walk_phase,
  output logic              frame_start,
  output logic              bounce
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Counter widths are kept at least one bit so degenerate parameter values
  // (ANIM_DIV = 1, HOLD_FRAMES <= 1) still elaborate cleanly.
  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0);

  localparam logic [10:0] X_MIN_W  = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W  = 11'(X_MAX);
  localparam logic [10:0] Y_MIN_W  = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX_W  = 11'(Y_MAX);
  localparam logic [9:0]  X_INIT_V = 10'(X_INIT);
  localparam logic [9:0]  Y_INIT_V = 10'(Y_INIT);

  state_t state;
  state_t state_next;

  logic          v_q;
  logic          armed;
  logic          vs_act;
  logic          vq_act;

  logic [AW-1:0] anim_cnt;
  logic [AW-1:0] anim_next;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_next;

  logic [9:0]    x_next;
  logic [9:0]    y_next;
  logic          dir_x_next;
  logic          dir_y_next;
  logic [1:0]    phase_next;
  logic          bounce_next;

  logic [11:0]   x_res;
  logic [11:0]   y_res;

  // One axis of step arithmetic. The position is widened to 11 bits so a
  // step past either limit is detected before it can wrap. A zero step is
  // treated as "stand still" and never reports a bounce, even when parked
  // on a limit. Result packing: {bounced, new_dir, new_pos[9:0]}.
  function automatic logic [11:0] axis_step(
    input logic [9:0]        pos,
    input logic              dir,
    input logic [STEP_W-1:0] step,
    input logic [10:0]       lo,
    input logic [10:0]       hi
  );
    logic [10:0] pos_w;
    logic [10:0] stp;
    logic [10:0] sum;
    logic [10:0] diff;
    logic [9:0]  npos;
    logic        ndir;
    logic        hit;
    pos_w = {1'b0, pos};
    stp   = 11'(step);
    sum   = pos_w + stp;
    diff  = pos_w - stp;
    npos  = pos;
    ndir  = dir;
    hit   = 1'b0;
    if (stp != 11'd0) begin
      if (dir) begin
        if (sum >= hi) begin
          npos = hi[9:0];
          ndir = 1'b0;
          hit  = 1'b1;
        end else begin
          npos = sum[9:0];
        end
      end else begin
        // Compare before subtracting so an underflow can never alias to a
        // large positive position.
        if (pos_w < (lo + stp)) begin
          npos = lo[9:0];
          ndir = 1'b1;
          hit  = 1'b1;
        end else begin
          npos = diff[9:0];
        end
      end
    end
    return {hit, ndir, npos};
  endfunction

  assign x_res = axis_step(sprite_x, dir_x, step_x, X_MIN_W, X_MAX_W);
  assign y_res = axis_step(sprite_y, dir_y, step_y, Y_MIN_W, Y_MAX_W);

  assign vs_act = (vsync == VSYNC_ACT);
  assign vq_act = (v_q == VSYNC_ACT);

  // Leading-edge detector. The armed flag only sets once vsync has been seen
  // inactive after reset, so a vsync held active across reset release does
  // not masquerade as a new frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q         <= ~VSYNC_ACT;
      armed       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      v_q <= vsync;
      if (!vs_act) begin
        armed <= 1'b1;
      end
      frame_start <= vs_act && !vq_act && armed;
    end
  end

  // State and datapath registers. Everything below is recomputed only in a
  // frame_start cycle; the next-value logic holds values otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sprite_x   <= X_INIT_V;
      sprite_y   <= Y_INIT_V;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      walk_phase <= 2'd0;
      anim_cnt   <= '0;
      hold_cnt   <= '0;
      bounce     <= 1'b0;
    end else begin
      state      <= state_next;
      sprite_x   <= x_next;
      sprite_y   <= y_next;
      dir_x      <= dir_x_next;
      dir_y      <= dir_y_next;
      walk_phase <= phase_next;
      anim_cnt   <= anim_next;
      hold_cnt   <= hold_next;
      bounce     <= bounce_next;
    end
  end

  // Next-state and next-value logic. Defaults hold every register, and the
  // bounce pulse defaults low so it lasts exactly one cycle.
  always_comb begin
    state_next  = state;
    x_next      = sprite_x;
    y_next      = sprite_y;
    dir_x_next  = dir_x;
    dir_y_next  = dir_y;
    phase_next  = walk_phase;
    anim_next   = anim_cnt;
    hold_next   = hold_cnt;
    bounce_next = 1'b0;

    if (frame_start) begin
      case (state)
        IDLE: begin
          // The enabling frame only arms motion; the first step lands on
          // the following frame.
          if (enable) begin
            state_next = MOVE;
          end
        end

        MOVE: begin
          if (!enable) begin
            state_next = IDLE;
          end else begin
            x_next      = x_res[9:0];
            dir_x_next  = x_res[10];
            y_next      = y_res[9:0];
            dir_y_next  = y_res[10];
            bounce_next = x_res[11] || y_res[11];

            if (anim_cnt == ANIM_LAST) begin
              anim_next  = '0;
              phase_next = walk_phase + 2'd1;
            end else begin
              anim_next = anim_cnt + AW'(1);
            end

            if (bounce_next && (HOLD_FRAMES > 0)) begin
              state_next = HOLD;
              hold_next  = '0;
            end
          end
        end

        HOLD: begin
          // Position, directions and phase stay frozen while the sprite
          // pauses against the wall.
          if (!enable) begin
            state_next = IDLE;
            hold_next  = '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state_next = MOVE;
            hold_next  = '0;
          end else begin
            hold_next = hold_cnt + HW'(1);
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sprite_motion_ctrl
//
// Directed bench for sprite_motion_ctrl with default parameters. Each frame
// task pushes the hand-derived post-frame state into a queue; an independent
// monitor waits for frame_start, then compares the registered outputs on the
// following cycle. Any frame_start with nothing expected, or any bounce
// outside an update cycle, is reported as a failure.
// -----------------------------------------------------------------------------
module tb_sprite_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic       enable;
  logic [2:0] step_x;
  logic [2:0] step_y;
  logic [9:0] sprite_x;
  logic [9:0] sprite_y;
  logic       dir_x;
  logic       dir_y;
  logic [1:0] walk_phase;
  logic       frame_start;
  logic       bounce;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       dx;
    logic       dy;
    logic [1:0] ph;
    logic       b;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_exp;
  exp_t mon_act;
  int   vectors     = 0;
  int   miscompares = 0;
  int   frame_idx   = 0;
  logic pending     = 1'b0;

  int cx;
  int cy;
  int m;

  sprite_motion_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .enable      (enable),
    .step_x      (step_x),
    .step_y      (step_y),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .dir_x       (dir_x),
    .dir_y       (dir_y),
    .walk_phase  (walk_phase),
    .frame_start (frame_start),
    .bounce      (bounce)
  );

  always #5 clk = ~clk;

  // Walk phase after a given number of enabled MOVE frames with ANIM_DIV = 8.
  function automatic int ph(input int moves);
    return (moves / 8) % 4;
  endfunction

  // Monitor: a frame_start announces an update on the next cycle.
  always @(negedge clk) begin
    if (!reset) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        mon_exp = exp_q.pop_front();
        mon_act = '{x: sprite_x, y: sprite_y, dx: dir_x, dy: dir_y,
                    ph: walk_phase, b: bounce};
        vectors++;
        if (mon_act !== mon_exp) begin
          miscompares++;
          $display("[TB] FAIL frame_update #%0d: got x=%0d y=%0d dx=%0b dy=%0b ph=%0d b=%0b, want x=%0d y=%0d dx=%0b dy=%0b ph=%0d b=%0b",
                   frame_idx, mon_act.x, mon_act.y, mon_act.dx, mon_act.dy, mon_act.ph, mon_act.b,
                   mon_exp.x, mon_exp.y, mon_exp.dx, mon_exp.dy, mon_exp.ph, mon_exp.b);
        end
        frame_idx++;
        pending = 1'b0;
      end else if (bounce !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL spurious_bounce: got bounce=%0b, want 0 at %0t", bounce, $time);
      end
      if (frame_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_frame_start: got pulse at %0t, want none", $time);
        end else begin
          pending = 1'b1;
        end
      end
    end
  end

  // One frame: present inputs, raise an active vsync edge, then scramble the
  // sampled inputs while vsync is still active to show they are ignored.
  task automatic applyStimulus(input logic en, input logic [2:0] sx, input logic [2:0] sy,
                               input int ex, input int ey, input logic edx, input logic edy,
                               input int eph, input logic eb);
    exp_t e;
    e = '{x: 10'(ex), y: 10'(ey), dx: edx, dy: edy, ph: 2'(eph), b: eb};
    @(negedge clk);
    enable = en;
    step_x = sx;
    step_y = sy;
    exp_q.push_back(e);
    @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    enable = ~en;
    step_x = ~sx;
    step_y = ~sy;
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Reset-value check of every output, compared as one packed word.
  task automatic checkOutput(input string name);
    logic [26:0] act;
    logic [26:0] want;
    act  = {sprite_x, sprite_y, dir_x, dir_y, walk_phase, frame_start, bounce};
    want = {10'd100, 10'd100, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got x=%0d y=%0d dx=%0b dy=%0b ph=%0d fs=%0b b=%0b, want x=100 y=100 dx=1 dy=1 ph=0 fs=0 b=0",
               name, sprite_x, sprite_y, dir_x, dir_y, walk_phase, frame_start, bounce);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset  = 1'b0;
    vsync  = 1'b1;
    enable = 1'b0;
    step_x = 3'd0;
    step_y = 3'd0;
    #12;
    checkOutput("reset_initial");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] start and walk");
    applyStimulus(1'b1, 3'd2, 3'd0, 100, 100, 1'b1, 1'b1, 0, 1'b0);
    applyStimulus(1'b1, 3'd2, 3'd0, 102, 100, 1'b1, 1'b1, 0, 1'b0);
    applyStimulus(1'b1, 3'd2, 3'd0, 104, 100, 1'b1, 1'b1, 0, 1'b0);
    applyStimulus(1'b1, 3'd2, 3'd0, 106, 100, 1'b1, 1'b1, 0, 1'b0);
    cx = 106;
    m  = 3;
    for (int k = 0; k < 41; k++) begin
      cx += 7;
      m++;
      applyStimulus(1'b1, 3'd7, 3'd0, cx, 100, 1'b1, 1'b1, ph(m), 1'b0);
    end
    m++;
    applyStimulus(1'b1, 3'd5, 3'd0, 398, 100, 1'b1, 1'b1, ph(m), 1'b0);

    $display("[TB] right bounce with hold");
    m++;
    applyStimulus(1'b1, 3'd3, 3'd0, 400, 100, 1'b0, 1'b1, ph(m), 1'b1);
    applyStimulus(1'b1, 3'd3, 3'd0, 400, 100, 1'b0, 1'b1, ph(m), 1'b0);
    applyStimulus(1'b1, 3'd3, 3'd0, 400, 100, 1'b0, 1'b1, ph(m), 1'b0);
    m++;
    applyStimulus(1'b1, 3'd3, 3'd0, 397, 100, 1'b0, 1'b1, ph(m), 1'b0);

    $display("[TB] left underflow clamp");
    cx = 397;
    for (int k = 0; k < 42; k++) begin
      cx -= 7;
      m++;
      applyStimulus(1'b1, 3'd7, 3'd0, cx, 100, 1'b0, 1'b1, ph(m), 1'b0);
    end
    m++;
    applyStimulus(1'b1, 3'd2, 3'd0, 101, 100, 1'b0, 1'b1, ph(m), 1'b0);
    m++;
    applyStimulus(1'b1, 3'd7, 3'd0, 100, 100, 1'b1, 1'b1, ph(m), 1'b1);
    applyStimulus(1'b1, 3'd7, 3'd0, 100, 100, 1'b1, 1'b1, ph(m), 1'b0);
    applyStimulus(1'b1, 3'd7, 3'd0, 100, 100, 1'b1, 1'b1, ph(m), 1'b0);

    $display("[TB] simultaneous bounce");
    cx = 100;
    cy = 100;
    for (int k = 0; k < 42; k++) begin
      cx += 7;
      cy += 7;
      m++;
      applyStimulus(1'b1, 3'd7, 3'd7, cx, cy, 1'b1, 1'b1, ph(m), 1'b0);
    end
    for (int k = 0; k < 6; k++) begin
      cy += 7;
      m++;
      applyStimulus(1'b1, 3'd0, 3'd7, cx, cy, 1'b1, 1'b1, ph(m), 1'b0);
    end
    m++;
    applyStimulus(1'b1, 3'd5, 3'd3, 399, 439, 1'b1, 1'b1, ph(m), 1'b0);
    m++;
    applyStimulus(1'b1, 3'd1, 3'd1, 400, 440, 1'b0, 1'b0, ph(m), 1'b1);
    applyStimulus(1'b1, 3'd1, 3'd1, 400, 440, 1'b0, 1'b0, ph(m), 1'b0);
    applyStimulus(1'b1, 3'd1, 3'd1, 400, 440, 1'b0, 1'b0, ph(m), 1'b0);
    m++;
    applyStimulus(1'b1, 3'd1, 3'd1, 399, 439, 1'b0, 1'b0, ph(m), 1'b0);

    $display("[TB] enable drop and resume");
    applyStimulus(1'b0, 3'd1, 3'd1, 399, 439, 1'b0, 1'b0, ph(m), 1'b0);
    applyStimulus(1'b0, 3'd1, 3'd1, 399, 439, 1'b0, 1'b0, ph(m), 1'b0);
    applyStimulus(1'b1, 3'd1, 3'd1, 399, 439, 1'b0, 1'b0, ph(m), 1'b0);
    m++;
    applyStimulus(1'b1, 3'd1, 3'd1, 398, 438, 1'b0, 1'b0, ph(m), 1'b0);

    $display("[TB] mid-frame reset with vsync held active");
    repeat (2) @(negedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("reset_midframe");
    @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(1'b1, 3'd2, 3'd0, 100, 100, 1'b1, 1'b1, 0, 1'b0);
    applyStimulus(1'b1, 3'd2, 3'd0, 102, 100, 1'b1, 1'b1, 0, 1'b0);

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL queue_drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Frame-synchronous motion controller for the walking sprite. It watches the vertical-sync output of the VGA timing generator and produces a tear-free sprite origin (`sprite_x`, `sprite_y`), travel directions and a 2-bit walk-animation phase. Outputs change only once per frame, during vertical blanking. It sits directly upstream of the sprite renderer and sprite ROM, and replaces free-running divider-based movement.

## Interface
- `X_MIN`, 100: left limit of the sprite origin.
- `X_MAX`, 400: right limit of the sprite origin.
- `Y_MIN`, 40: top limit of the sprite origin.
- `Y_MAX`, 440: bottom limit of the sprite origin.
- `X_INIT`, 100: origin x after reset.
- `Y_INIT`, 100: origin y after reset.
- `STEP_W`, 3: width of the step inputs.
- `ANIM_DIV`, 8: MOVE frames per walk-phase increment (≥1).
- `HOLD_FRAMES`, 2: frames frozen after a bounce (0 = no hold).
- `VSYNC_ACT`, 0: active level of `vsync`.
- `clk` in 1: pixel clock; the only clock.
- `reset` in 1: asynchronous, active-low reset.
- `vsync` in 1: vertical sync from the timing generator.
- `enable` in 1: motion enable.
- `step_x` in STEP_W: pixels per frame, x axis.
- `step_y` in STEP_W: pixels per frame, y axis.
- `sprite_x` out 10: registered origin x.
- `sprite_y` out 10: registered origin y.
- `dir_x` out 1: 1 = right, 0 = left.
- `dir_y` out 1: 1 = down, 0 = up.
- `walk_phase` out 2: animation frame select for the sprite ROM.
- `frame_start` out 1: one-cycle pulse at the leading edge of vsync.
- `bounce` out 1: one-cycle pulse when either axis reverses.

## Operation
- **Reset state.** While `reset`=0, all registers are forced asynchronously:
  - `sprite_x`=X_INIT, `sprite_y`=Y_INIT, `dir_x`=1, `dir_y`=1;
  - `walk_phase`=0, `frame_start`=0, `bounce`=0;
  - state IDLE; anim and hold counters = 0; vsync history register = inactive.
- **Frame detection.** `vsync` is registered into `v_q`. A leading edge (vsync active, `v_q` inactive) sets `frame_start` for exactly one cycle. All actions below occur only in a `frame_start` cycle.
- **States.**
  - IDLE: if `enable`=1, go to MOVE. No movement on this frame.
  - MOVE:
    - if `enable`=0, go to IDLE; position and phase are kept;
    - otherwise apply the step;
    - if a bounce occurred and HOLD_FRAMES>0, go to HOLD with the hold counter = 0.
  - HOLD: position, directions and phase are frozen.
    - if `enable`=0, go to IDLE and clear the hold counter;
    - otherwise the hold counter increments; when it reaches HOLD_FRAMES-1, clear it and go to MOVE.
- **Step arithmetic.** Computed in 11 bits, so underflow and overflow are never truncated.
  - x axis: nx = x + step_x if `dir_x`=1, else x − step_x.
  - If `dir_x`=1 and nx ≥ X_MAX: x=X_MAX, `dir_x`=0.
  - If `dir_x`=0 and x < X_MIN + step_x: x=X_MIN, `dir_x`=1.
  - Otherwise x=nx.
  - The y axis follows the same rules with `dir_y` and Y_MIN/Y_MAX.
  - A step of 0 moves nothing and never bounces.
- **Bounce.** `bounce` pulses once if either axis or both reverse on the same frame; a simultaneous bounce flips both directions.
- **Walk phase.** In MOVE with `enable`=1, the anim counter increments each frame. At ANIM_DIV−1 it wraps to 0 and `walk_phase` increments, wrapping 3→0. The counter is held in IDLE and HOLD.
- **Parameter legality.** X_MIN < X_MAX ≤ 1023 and X_MIN ≤ X_INIT ≤ X_MAX; the same holds for y. Step values are below the span. Violations are unsupported.

## Timing
- Cycle N: first cycle in which vsync is sampled active.
- Cycle N+1: `frame_start`=1.
- Cycle N+2: updated `sprite_x`, `sprite_y`, directions, `walk_phase` and state are visible. `bounce`=1 during N+2 only.
- Latency from vsync edge to new position is 2 clocks, well within vertical blanking.
- `step_x`, `step_y` and `enable` are sampled in the `frame_start` cycle only. Changes at other times have no effect until the next frame.
- All outputs are registered, with no combinational paths from inputs.
- Reset asserted mid-frame forces reset values immediately. After release, the first `frame_start` requires a fresh inactive→active vsync transition.
- vsync held active across reset release produces no `frame_start`.

## Test plan
- **Reset.** Assert reset mid-frame → immediately x=100, y=100, `dir_x`=1, `dir_y`=1, `walk_phase`=0, `frame_start`=0, `bounce`=0. Holding vsync active through release yields no pulse.
- **Start and walk.** `enable`=1, `step_x`=2, `step_y`=0.
  - Frame 1: IDLE→MOVE, x stays 100.
  - Frames 2, 3, 4: x = 102, 104, 106, each visible 2 clocks after the vsync edge.
- **Right bounce with hold.** x=398, `step_x`=3, HOLD_FRAMES=2.
  - Next frame: x=400, `dir_x`=0, one `bounce` pulse.
  - Next 2 frames: x=400.
  - Following frame: x=397.
- **Left underflow clamp.** x=101, `dir_x`=0, `step_x`=7 → x=100, `dir_x`=1, `bounce`=1, no wrap to a large value.
- **Simultaneous bounce.** x=399, y=439, both steps=1, both directions positive → x=400, y=440, `dir_x`=0, `dir_y`=0, exactly one `bounce` pulse.
- **Animation and enable.** ANIM_DIV=8.
  - After 8 MOVE frames: `walk_phase`=1; after 32: 0.
  - Drop `enable` → IDLE at next frame, x and phase frozen.
  - Re-enable → resumes after one frame.
